// File: rtl/seq_divider.sv
// Sequential restoring divider: 7-bit dividend by 4-bit divisor, one quotient bit per cycle.
// Optional macro DIV_ZERO_CHECK_EN short-circuits divide-by-zero and raises dz.
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [6:0] quotient,
    output logic [3:0] remainder,
    output logic       dz
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] dvd_q, dvd_d;
    logic [3:0] dvs_q, dvs_d;
    logic [3:0] rem_q, rem_d;
    logic [6:0] quo_q, quo_d;
    logic [3:0] rmd_q, rmd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifdef DIV_ZERO_CHECK_EN
    logic       dz_q, dz_d;
`endif

    logic [4:0] part;
    logic [4:0] diff;
    logic       qbit;
    logic [3:0] rem_step;

    // Quotient bits shift into the dividend register as dividend bits shift out.
    always_comb begin
        part     = {rem_q, dvd_q[6]};
        diff     = part - {1'b0, dvs_q};
        qbit     = (part >= {1'b0, dvs_q});
        rem_step = qbit ? diff[3:0] : part[3:0];

        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
`ifdef DIV_ZERO_CHECK_EN
        dz_d    = dz_q;
`endif

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = 4'd0;
                    cnt_d   = 3'd6;
                    state_d = StRun;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
`ifdef DIV_ZERO_CHECK_EN
                if (dvs_q == 4'd0) begin
                    state_d = StDone;
                    quo_d   = 7'h7F;
                    rmd_d   = dvd_q[3:0];
                    dz_d    = 1'b1;
                    cnt_d   = 3'd0;
                end else
`endif
                begin
                    rem_d = rem_step;
                    dvd_d = {dvd_q[5:0], qbit};
                    if (cnt_q == 3'd0) begin
                        state_d = StDone;
                        quo_d   = {dvd_q[5:0], qbit};
                        rmd_d   = rem_step;
`ifdef DIV_ZERO_CHECK_EN
                        dz_d    = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            dvd_q   <= 7'd0;
            dvs_q   <= 4'd0;
            rem_q   <= 4'd0;
            quo_q   <= 7'd0;
            rmd_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_ZERO_CHECK_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
`ifdef DIV_ZERO_CHECK_EN
    assign dz        = dz_q;
`else
    assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases plus a randomized product sweep.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [6:0] quotient;
    logic [3:0] remainder;
    logic       dz;

    seq_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int z;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; divide-by-zero yields all-ones and the low dividend bits.
    task automatic issue(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = 127;
            e.r = a % 16;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
`ifdef DIV_ZERO_CHECK_EN
        e.z   = (b == 0) ? 1 : 0;
        e.cyc = cyc + ((b == 0) ? 2 : 8);
`else
        e.z   = 0;
        e.cyc = cyc + 8;
`endif
        sb.push_back(e);
        dividend = 7'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", int'(quotient), e.q);
                chk("remainder", int'(remainder), e.r);
                chk("dz", int'(dz), e.z);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", int'(busy), 0);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 7'd0;
        divisor  = 4'd0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dz", int'(dz), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // 105/7: busy for exactly 7 cycles, then done.
        issue(105, 7);
        for (int i = 0; i < 7; i++) begin
            chk("busy_run", int'(busy), 1);
            chk("done_run", int'(done), 0);
            tick();
        end
        chk("done_after_7", int'(done), 1);
        repeat (3) tick();
        chk("quotient_hold", int'(quotient), 15);
        chk("done_dropped", int'(done), 0);
        chk("busy_idle", int'(busy), 0);

        // Back-to-back chain, each started in the previous DONE cycle.
        issue(100, 9);
        wait_done();
        issue(127, 1);
        wait_done();
        issue(5, 15);
        wait_done();
        tick();

        // Start re-pulsed mid-run with other operands must be ignored.
        issue(50, 3);
        repeat (2) tick();
        dividend = 7'd99;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        tick();

        // Reset in the middle of 60/4, then a clean rerun.
        issue(60, 4);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        sb.delete();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        issue(60, 4);
        wait_done();
        tick();

        // Divide by zero.
        issue(7'h5A, 0);
        wait_done();
        tick();

        // Random sweep: dividend is a product of a 3-bit and a 4-bit value.
        for (int i = 0; i < 200; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 7)) * int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) tick();
            issue(a, b);
            wait_done();
        end

        repeat (4) tick();
        chk("pending_results", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 clk  input  1  clock; all state changes on the rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 start  input  1  request pulse; sampled on a rising edge.
REQ-004 dividend  input  7  unsigned dividend; the width matches the product result bus.
REQ-005 divisor  input  4  unsigned divisor.
REQ-006 busy  output  1  high while a division is in progress.
REQ-007 done  output  1  one-cycle pulse marking valid results.
REQ-008 quotient  output  7  unsigned quotient; holds its value until the next result.
REQ-009 remainder  output  4  unsigned remainder; holds its value until the next result.
REQ-010 dz  output  1  divide-by-zero flag; updated together with done.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE; busy=1 only in RUN, and done=1 only in DONE.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL capture dividend and divisor, clear the partial remainder, load the bit counter with 6, and enter RUN.
REQ-013 In DONE with start=0, the next edge SHALL return the FSM to IDLE.
REQ-014 start SHALL be ignored in RUN; operand input changes during RUN SHALL have no effect.
REQ-015 Each RUN edge SHALL perform one restoring step:
- partial P = {rem[3:0], next dividend bit, MSB first} (5 bits)
- if P >= {0, divisor}: rem = (P - divisor)[3:0] and the quotient bit = 1
- otherwise: rem = P[3:0] and the quotient bit = 0
REQ-016 After the 7th RUN edge (counter = 0), the FSM SHALL enter DONE and update quotient, remainder and dz on the same edge.
REQ-017 Latency SHALL be fixed: done=1 for exactly the one cycle following the 7th edge after the capturing edge, for any divisor other than 0.
REQ-018 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor whenever divisor != 0.
REQ-019 Back-to-back operation: start during DONE SHALL be accepted with no gap, and done SHALL drop on that edge.
REQ-020 quotient, remainder and dz SHALL change only on the edge that enters DONE or on reset.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, dz=0, and clear the counter and internal registers.
REQ-022 Reset asserted mid-RUN SHALL abort the division with no done pulse; a start after reset release SHALL run normally.

Configuration
REQ-023 Macro DIV_ZERO_CHECK_EN:
- Defined, with captured divisor = 0: the FSM SHALL skip RUN and enter DONE on the edge after capture (done one cycle after the capturing edge), with quotient=7'h7F, remainder=dividend[3:0] and dz=1.
- Defined, with divisor != 0: dz SHALL be 0.
- Not defined: dz SHALL be tied to 0, and divisor 0 SHALL run the full 7 RUN steps per REQ-015, giving quotient=7'h7F and remainder=dividend[3:0] with normal latency.

Verification
REQ-024 dividend=105, divisor=7, start pulse -> busy for 7 cycles, then done with quotient=15, remainder=0, dz=0.
REQ-025 Sequence 100/9, then 127/1, then 5/15, each started in the DONE cycle of the previous operation -> results 11 r1, 127 r0 and 0 r5, with done pulses exactly 8 cycles apart.
REQ-026 start re-pulsed mid-RUN with new operands -> ignored; the original result is delivered on schedule.
REQ-027 rst asserted at RUN step 3 of 60/4 -> outputs zeroed immediately, no done pulse; a following 60/4 run -> 15 r0.
REQ-028 divisor=0, dividend=7'h5A:
- With DIV_ZERO_CHECK_EN: done one cycle after capture, quotient=7'h7F, remainder=4'hA, dz=1.
- Without it: done after 7 cycles with the same quotient and remainder, dz=0.
REQ-029 Random sweep of 200 vectors, dividend taken as the product of a random 3-bit by 4-bit pair -> quotient*divisor + remainder = dividend and remainder < divisor for every nonzero divisor.
